// File: rtl/sa_ram_fifo_ctrl_64x129.sv
// Valid/ready FIFO controller for one sa_ram_rwsp_64x129 macro.
// The macro's two-cycle read (address register, output register) is hidden behind
// a small credit-managed output skid buffer.
module sa_ram_fifo_ctrl_64x129 #(
    parameter int unsigned DW   = 129,
    parameter int unsigned AW   = 6,
    parameter int unsigned SKID = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   count,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    output logic [31:0]   ram_pd
);

    localparam int unsigned Depth = 2 ** AW;
    localparam int unsigned SW    = $clog2(SKID + 1);  // skid occupancy width
    localparam int unsigned PW    = $clog2(SKID);      // skid pointer width
    localparam int unsigned CW    = SW + 1;            // credit width, holds 0..SKID+1

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [SW-1:0] skid_cnt_q, skid_cnt_d;
    logic [PW-1:0] skid_hd_q, skid_hd_d;
    logic [PW-1:0] skid_tl_q, skid_tl_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] skid_mem_q [SKID];

    logic          push;
    logic          pop;
    logic          issue;
    logic          skid_wr;
    logic [CW-1:0] credit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshakes, read-issue credit and RAM control outputs.
    always_comb begin
        in_ready  = !reset && (ram_cnt_q != (AW+1)'(Depth));
        push      = in_valid && in_ready;
        out_valid = !reset && (skid_cnt_q != '0);
        pop       = out_valid && out_ready;
        // Skid slots not yet spoken for; a pop this cycle frees one immediately.
        credit    = CW'(SKID) + CW'(pop) - CW'(skid_cnt_q) - CW'(s1_q) - CW'(s2_q);
        issue     = !reset && (ram_cnt_q != '0) && (credit != '0);
        // Gated by reset so a read in flight at reset never lands in the skid.
        skid_wr   = !reset && s2_q;

        ram_we    = push;
        ram_wa    = wp_q;
        ram_di    = in_data;
        ram_re    = issue;
        ram_ra    = rp_q;
        ram_ore   = !reset && s1_q;
        ram_pd    = '0;
        out_data  = skid_mem_q[skid_hd_q];
        count     = count_q;
    end

    // Next-state for pointers, counters and the read pipeline flags.
    always_comb begin
        wp_d       = push ? wp_q + 1'b1 : wp_q;
        rp_d       = issue ? rp_q + 1'b1 : rp_q;
        ram_cnt_d  = ram_cnt_q + (AW+1)'(push) - (AW+1)'(issue);
        s1_d       = issue;
        s2_d       = s1_q;
        skid_cnt_d = skid_cnt_q + SW'(skid_wr) - SW'(pop);
        skid_hd_d  = pop ? ptr_inc(skid_hd_q) : skid_hd_q;
        skid_tl_d  = skid_wr ? ptr_inc(skid_tl_q) : skid_tl_q;
        count_d    = ram_cnt_d + (AW+1)'(s1_d) + (AW+1)'(s2_d) + (AW+1)'(skid_cnt_d);
    end

    // Control state register; reset flushes everything except RAM and skid data.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            ram_cnt_q  <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            skid_cnt_q <= '0;
            skid_hd_q  <= '0;
            skid_tl_q  <= '0;
            count_q    <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            ram_cnt_q  <= ram_cnt_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            skid_cnt_q <= skid_cnt_d;
            skid_hd_q  <= skid_hd_d;
            skid_tl_q  <= skid_tl_d;
            count_q    <= count_d;
        end
    end

    // Skid data storage; no reset needed, occupancy qualifies it.
    always_ff @(posedge clk) begin
        if (skid_wr) begin
            skid_mem_q[skid_tl_q] <= ram_dout;
        end
    end

    // The credit rule must keep the skid from ever overflowing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(skid_wr && !pop && (skid_cnt_q == SW'(SKID))));
        end
    end

endmodule
